// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State encoding and port identifiers used across the arbiter slice.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and shared memory bus signals.
// slave is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              err;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready,
    output d_rdata, d_ready,
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    output err
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready,
    input  d_rdata, d_ready,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    input  err
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants made while fetch is waiting.
// Clear wins over increment; o_sat flags the limit.
module starve_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = (r_cnt == W'(MAX));
  assign o_sat = w_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports.
// Data has priority; fetch wins once the starvation limit is hit.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  state_t r_state;
  state_t w_state_nxt;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_ready;
  logic              r_d_ready;
  logic              r_err;

  logic w_grant;
  logic w_gport;
  logic w_elig_i;
  logic w_elig_d;
  logic w_sat;
  logic w_inc;
  logic w_clr;
  logic w_ack_i;
  logic w_ack_d;

  // A port still shows its stale req in its own ready cycle.
  assign w_elig_i = bus.if_req & ~r_if_ready;
  assign w_elig_d = bus.d_req & ~r_d_ready;

  assign w_ack_i = (r_state == BUSY_I) & bus.mem_ack;
  assign w_ack_d = (r_state == BUSY_D) & bus.mem_ack;

  assign w_inc = w_grant & (w_gport == PORT_D) & w_elig_i;
  assign w_clr = ~bus.if_req
               | (w_grant & (w_gport == PORT_I));

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_sat (w_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gport     = PORT_D;
    unique case (r_state)
      IDLE: begin
        if (w_elig_d && !(w_sat && w_elig_i)) begin
          w_grant     = 1'b1;
          w_gport     = PORT_D;
          w_state_nxt = BUSY_D;
        end else if (w_elig_i) begin
          w_grant     = 1'b1;
          w_gport     = PORT_I;
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      if ((r_state == IDLE) && bus.mem_ack) r_err <= 1'b1;
      unique case (1'b1)
        w_grant: begin
          r_mem_req <= 1'b1;
          if (w_gport == PORT_D) begin
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
          end else begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= bus.if_addr;
          end
        end
        w_ack_i: begin
          r_mem_req  <= 1'b0;
          r_if_rdata <= bus.mem_rdata;
          r_if_ready <= 1'b1;
        end
        w_ack_d: begin
          r_mem_req <= 1'b0;
          r_d_rdata <= bus.mem_rdata;
          r_d_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: random requesters and memory, transaction model,
// queue-based monitor, plus directed fetch/store/collision/reset cases.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  typedef struct {
    int          cyc;
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t gq[$];
  txn_t rq[$];
  logic [31:0] mem [logic [31:0]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit   i_en, d_en, resp_en;
  int   i_pct, d_pct, lat_min, lat_max;

  bit   m_busy;
  logic m_port;
  int   m_starve;
  bit   m_rdy [2];
  bit   m_err;

  function automatic void chk(string name,
                              logic [63:0] got,
                              logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'h9E37_79B1;
  endfunction

  // Memory: random latency, backing store, garbage rdata when idle.
  initial begin
    bit started;
    int w;
    started = 0;
    w = 0;
    forever begin
      @(posedge clk); #2;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (!rst_n) begin
        started = 0;
      end else if (resp_en && bus.mem_req) begin
        if (!started) begin
          started = 1;
          w = int'($urandom_range(lat_max, lat_min));
        end
        if (w == 0) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_rd(bus.mem_addr);
          started = 0;
        end else begin
          w--;
        end
      end
    end
  end

  // Fetch requester: level req held until the cycle after if_ready.
  initial begin
    bit seen;
    seen = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        bus.if_req = 1'b0;
        seen = 0;
      end else begin
        if (seen) begin
          bus.if_req = 1'b0;
          seen = 0;
        end
        if (bus.if_ready) begin
          seen = 1;
        end else if (i_en) begin
          if (!bus.if_req || bus.mem_req)
            bus.if_addr = 32'($urandom_range(63, 0)) << 2;
          if (!bus.if_req && $urandom_range(99, 0) < i_pct)
            bus.if_req = 1'b1;
        end
      end
    end
  end

  // Data requester, same protocol; payload scribbled while not needed.
  initial begin
    bit seen;
    seen = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        bus.d_req = 1'b0;
        seen = 0;
      end else begin
        if (seen) begin
          bus.d_req = 1'b0;
          seen = 0;
        end
        if (bus.d_ready) begin
          seen = 1;
        end else if (d_en) begin
          if (!bus.d_req || bus.mem_req) begin
            bus.d_we    = 1'($urandom_range(1, 0));
            bus.d_addr  = 32'($urandom_range(15, 0)) << 2;
            bus.d_wdata = $urandom;
          end
          if (!bus.d_req && $urandom_range(99, 0) < d_pct)
            bus.d_req = 1'b1;
        end
      end
    end
  end

  // Reference model: decides each cycle's grant/completion from the rules.
  initial begin
    bit   ei, ed, gi, gd;
    bit   nr [2];
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy   = 0;
        m_starve = 0;
        m_rdy    = '{0, 0};
        m_err    = 0;
      end else begin
        ei = bus.if_req && !m_rdy[PORT_I];
        ed = bus.d_req && !m_rdy[PORT_D];
        gi = 0;
        gd = 0;
        nr = '{0, 0};
        if (!m_busy) begin
          if (bus.mem_ack) m_err = 1;
          if (ed && !(m_starve == SMAX && ei)) gd = 1;
          else if (ei) gi = 1;
          if (gd || gi) begin
            t.cyc  = cyc + 1;
            t.port = gd ? PORT_D : PORT_I;
            t.we   = gd ? bus.d_we : 1'b0;
            t.addr = gd ? bus.d_addr : bus.if_addr;
            t.data = gd ? bus.d_wdata : 32'h0;
            gq.push_back(t);
            m_busy = 1;
            m_port = t.port;
          end
        end else if (bus.mem_ack) begin
          t.cyc  = cyc + 1;
          t.port = m_port;
          t.we   = 1'b0;
          t.addr = 32'h0;
          t.data = bus.mem_rdata;
          rq.push_back(t);
          nr[m_port] = 1;
          m_busy = 0;
        end
        if (!bus.if_req || gi) m_starve = 0;
        else if (gd && ei && m_starve < SMAX) m_starve++;
        m_rdy = nr;
      end
    end
  end

  // Monitor: per-cycle level checks plus in-order scoreboard pops.
  initial begin
    txn_t        t;
    logic        prev_req;
    logic [31:0] cur_addr;
    logic        cur_we;
    prev_req = 1'b0;
    cur_addr = '0;
    cur_we   = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        prev_req = 1'b0;
        continue;
      end
      chk("mem_req", 64'(bus.mem_req), 64'(m_busy));
      chk("if_ready", 64'(bus.if_ready), 64'(m_rdy[PORT_I]));
      chk("d_ready", 64'(bus.d_ready), 64'(m_rdy[PORT_D]));
      chk("err", 64'(bus.err), 64'(m_err));
      while (gq.size() != 0 && gq[0].cyc < cyc) begin
        t = gq.pop_front();
        total++; bad++;
        $display("FAIL grant_missing: got none want cyc %0d", t.cyc);
      end
      while (rq.size() != 0 && rq[0].cyc < cyc) begin
        t = rq.pop_front();
        total++; bad++;
        $display("FAIL ready_missing: got none want cyc %0d", t.cyc);
      end
      if (bus.mem_req && !prev_req) begin
        if (gq.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_extra: got addr %h want none",
                   bus.mem_addr);
        end else begin
          t = gq.pop_front();
          chk("grant_cyc", 64'(cyc), 64'(t.cyc));
          chk("grant_we", 64'(bus.mem_we), 64'(t.we));
          chk("grant_addr", 64'(bus.mem_addr), 64'(t.addr));
          if (t.we) chk("grant_wdata", 64'(bus.mem_wdata), 64'(t.data));
          cur_addr = t.addr;
          cur_we   = t.we;
        end
      end else if (bus.mem_req) begin
        chk("addr_hold", 64'(bus.mem_addr), 64'(cur_addr));
        chk("we_hold", 64'(bus.mem_we), 64'(cur_we));
      end
      prev_req = bus.mem_req;
      if (bus.if_ready || bus.d_ready) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL ready_extra: got i=%0b d=%0b want none",
                   bus.if_ready, bus.d_ready);
        end else begin
          t = rq.pop_front();
          chk("rdy_cyc", 64'(cyc), 64'(t.cyc));
          chk("rdy_port", 64'(bus.d_ready), 64'(t.port));
          chk("rdata", 64'(t.port ? bus.d_rdata : bus.if_rdata),
              64'(t.data));
        end
      end
    end
  end

  task automatic issue(input logic port, input logic we,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       output logic [31:0] rdo, output int lat);
    @(posedge clk); #3;
    if (port == PORT_D) begin
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wd;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    lat = 0;
    rdo = '0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (port == PORT_D ? bus.d_ready : bus.if_ready) begin
        lat = n;
        rdo = (port == PORT_D) ? bus.d_rdata : bus.if_rdata;
        break;
      end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL issue_timeout: got no ready want ready port %0b",
               port);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while ((bus.if_req || bus.d_req || bus.mem_req) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy want idle");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          ni, nd;
    logic        first;
    bit          got_first;
    rst_n = 1'b0;
    i_en = 0; d_en = 0; resp_en = 1;
    i_pct = 0; d_pct = 0; lat_min = 0; lat_max = 0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
    chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    chk("rst_if_ready", 64'(bus.if_ready), 64'(0));
    chk("rst_d_ready", 64'(bus.d_ready), 64'(0));
    chk("rst_if_rdata", 64'(bus.if_rdata), 64'(0));
    chk("rst_d_rdata", 64'(bus.d_rdata), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    @(posedge clk); #4;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    mem[32'h40] = 32'h0050_0093;
    issue(PORT_I, 1'b0, 32'h40, 32'h0, rd, lat);
    chk("fetch_data", 64'(rd), 64'(32'h0050_0093));
    chk("fetch_lat", 64'(lat), 64'(2));

    wait_idle();
    lat_min = 2; lat_max = 2;
    issue(PORT_D, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, lat);
    chk("store_lat", 64'(lat), 64'(4));
    issue(PORT_D, 1'b0, 32'h10, 32'h0, rd, lat);
    chk("load_lat", 64'(lat), 64'(4));
    chk("load_data", 64'(rd), 64'(32'hDEAD_BEEF));

    wait_idle();
    lat_min = 1; lat_max = 1;
    @(posedge clk); #3;
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h24;
    ni = 0; nd = 0; got_first = 0; first = PORT_I;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (!got_first && (bus.if_ready || bus.d_ready)) begin
        got_first = 1;
        first = bus.d_ready ? PORT_D : PORT_I;
      end
      if (bus.if_ready) ni++;
      if (bus.d_ready) nd++;
    end
    chk("collide_first", 64'(first), 64'(PORT_D));
    chk("collide_i_cnt", 64'(ni), 64'(1));
    chk("collide_d_cnt", 64'(nd), 64'(1));

    wait_idle();
    @(posedge clk); #3;
    bus.mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("spurious_err", 64'(bus.err), 64'(1));

    lat_min = 0; lat_max = 3;
    i_en = 1; d_en = 1;
    for (int ph = 0; ph < 4; ph++) begin
      i_pct = (ph == 0) ? 100 : int'($urandom_range(90, 10));
      d_pct = (ph == 0) ? 100 : int'($urandom_range(100, 20));
      repeat (700) @(posedge clk);
    end
    i_en = 0; d_en = 0;
    wait_idle();
    chk("sticky_err", 64'(bus.err), 64'(1));

    resp_en = 0;
    @(posedge clk); #3;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    for (int n = 0; n < 10 && !bus.mem_req; n++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_req", 64'(bus.mem_req), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_req", 64'(bus.mem_req), 64'(0));
    chk("arst_mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("arst_d_ready", 64'(bus.d_ready), 64'(0));
    chk("arst_if_rdata", 64'(bus.if_rdata), 64'(0));
    chk("arst_d_rdata", 64'(bus.d_rdata), 64'(0));
    chk("arst_err", 64'(bus.err), 64'(0));
    gq.delete();
    rq.delete();
    bus.d_req = 1'b0;
    resp_en = 1;
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    lat_min = 0; lat_max = 0;
    issue(PORT_I, 1'b0, 32'h40, 32'h0, rd, lat);
    chk("post_rst_fetch", 64'(rd), 64'(32'h0050_0093));

    wait_idle();
    repeat (3) @(posedge clk);
    chk("gq_empty", 64'(gq.size()), 64'(0));
    chk("rq_empty", 64'(rq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
